// File: rtl/systolic_skew_feeder_if.sv
// Handshake and operand bus between the upstream source and the skew feeder.
interface systolic_skew_feeder_if #(
    parameter int unsigned LANES       = 4,
    parameter int unsigned OPND_BWIDTH = 8,
    parameter int unsigned LEN_BWIDTH  = 8
) ();

    logic                         start;
    logic [LEN_BWIDTH-1:0]        len;
    logic                         in_valid;
    logic                         in_ready;
    logic [LANES*OPND_BWIDTH-1:0] in_data;
    logic [LANES*OPND_BWIDTH-1:0] out_data;
    logic [LANES-1:0]             out_valid;
    logic                         compute;
    logic                         busy;
    logic                         done;

    // Upstream / controller side.
    modport master (
        output start, len, in_valid, in_data,
        input  in_ready, out_data, out_valid, compute, busy, done
    );

    // Feeder side.
    modport slave (
        input  start, len, in_valid, in_data,
        output in_ready, out_data, out_valid, compute, busy, done
    );

endinterface

// File: rtl/systolic_skew_feeder.sv
// Skewing operand feeder for one edge of the systolic array: lane i is delayed
// by i extra shift stages, and the tile is drained with LANES-1 zero pads.
module systolic_skew_feeder #(
    parameter int unsigned LANES       = 4,
    parameter int unsigned OPND_BWIDTH = 8,
    parameter int unsigned LEN_BWIDTH  = 8
) (
    input logic                 clk,
    input logic                 rst,
    systolic_skew_feeder_if.slave bus
);

    localparam int unsigned W = OPND_BWIDTH;
    // dcnt value on the last drain cycle (LANES-1 drain cycles in total).
    localparam logic [LEN_BWIDTH-1:0] DrainLast =
        LEN_BWIDTH'((LANES > 1) ? (LANES - 2) : 32'd0);

    typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDone} state_e;

    state_e                state_q, state_d;
    logic [LEN_BWIDTH-1:0] len_q, len_d;
    logic [LEN_BWIDTH-1:0] cnt_q, cnt_d;
    logic [LEN_BWIDTH-1:0] dcnt_q, dcnt_d;
    logic [LEN_BWIDTH-1:0] cnt_inc;
    logic                  compute_q;

    logic shift;        // all chains advance one stage this edge
    logic fill;         // stage 0 takes real data (1) or a zero pad (0)
    logic clear_chains; // tile start: wipe data and valid chains
    logic clear_valid;  // tile end: drop valid bits, keep data

    assign cnt_inc = cnt_q + 1'b1;

    // Next-state logic and decoded control strobes.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        dcnt_d       = dcnt_q;
        shift        = 1'b0;
        fill         = 1'b0;
        clear_chains = 1'b0;
        clear_valid  = 1'b0;
        bus.in_ready = 1'b0;
        bus.done     = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    len_d        = bus.len;
                    cnt_d        = '0;
                    dcnt_d       = '0;
                    clear_chains = 1'b1;
                    state_d      = (bus.len == '0) ? StDone : StFeed;
                end
            end
            StFeed: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    shift = 1'b1;
                    fill  = 1'b1;
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = (LANES == 1) ? StDone : StDrain;
                    end
                end
            end
            StDrain: begin
                shift = 1'b1;
                if (dcnt_q == DrainLast) begin
                    state_d = StDone;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            StDone: begin
                bus.done    = 1'b1;
                clear_valid = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state registers; COMPUTE marks the cycle after every shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            len_q     <= '0;
            cnt_q     <= '0;
            dcnt_q    <= '0;
            compute_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            dcnt_q    <= dcnt_d;
            compute_q <= shift;
        end
    end

    assign bus.compute = compute_q;
    assign bus.busy    = (state_q != StIdle);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [W-1:0] d_q [gi+1];
        logic         v_q [gi+1];

        // Lane delay chain of gi+1 stages; holds on stall so lanes stay aligned.
        always_ff @(posedge clk) begin
            if (rst || clear_chains) begin
                for (int j = 0; j <= gi; j++) begin
                    d_q[j] <= '0;
                    v_q[j] <= 1'b0;
                end
            end else if (shift) begin
                d_q[0] <= fill ? bus.in_data[gi*W +: W] : '0;
                v_q[0] <= fill;
                for (int j = 1; j <= gi; j++) begin
                    d_q[j] <= d_q[j-1];
                    v_q[j] <= v_q[j-1];
                end
            end else if (clear_valid) begin
                for (int j = 0; j <= gi; j++) begin
                    v_q[j] <= 1'b0;
                end
            end
        end

        assign bus.out_data[gi*W +: W] = d_q[gi];
        assign bus.out_valid[gi]       = v_q[gi];
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench: a 4-lane and a 1-lane feeder run the same tiles and are
// compared each cycle against a timeline model derived from the accept pattern.
module tb_systolic_skew_feeder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    systolic_skew_feeder_if #(.LANES(4), .OPND_BWIDTH(8), .LEN_BWIDTH(8)) bus4 ();
    systolic_skew_feeder_if #(.LANES(1), .OPND_BWIDTH(8), .LEN_BWIDTH(8)) bus1 ();

    systolic_skew_feeder #(.LANES(4), .OPND_BWIDTH(8), .LEN_BWIDTH(8)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    systolic_skew_feeder #(.LANES(1), .OPND_BWIDTH(8), .LEN_BWIDTH(8)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Current tile description shared by the model.
    int          tk;
    int          tlast;
    logic [31:0] tvec [64];
    bit          tacc [128];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_shift(input int lanes, input int c);
        return tacc[c] || (tk > 0 && c > tlast && c < tlast + lanes);
    endfunction

    function automatic int done_cyc(input int lanes);
        return (tk == 0) ? 1 : tlast + lanes;
    endfunction

    // Expected outputs in cycle t of the tile (START was in cycle 0).
    task automatic check_dut(input int lanes, input int t, input logic [31:0] od,
                             input logic [3:0] ov, input logic ir, input logic bz,
                             input logic dn, input logic cp);
        int          dc, fe, n, idx;
        logic [31:0] eod;
        logic [3:0]  eov;
        dc  = done_cyc(lanes);
        fe  = (tk == 0) ? 0 : tlast;
        n   = 0;
        for (int c = 1; c < t; c++) if (is_shift(lanes, c)) n++;
        eod = '0;
        eov = '0;
        for (int i = 0; i < lanes; i++) begin
            idx = n - 1 - i;
            if (idx >= 0 && idx < tk) begin
                eod[i*8 +: 8] = tvec[idx][i*8 +: 8];
                eov[i]        = (t <= dc);
            end
        end
        chk($sformatf("L%0d t%0d in_ready", lanes, t), 32'(ir), 32'(t >= 1 && t <= fe));
        chk($sformatf("L%0d t%0d busy", lanes, t), 32'(bz), 32'(t >= 1 && t <= dc));
        chk($sformatf("L%0d t%0d done", lanes, t), 32'(dn), 32'(t == dc));
        chk($sformatf("L%0d t%0d compute", lanes, t), 32'(cp),
            32'(t >= 1 && is_shift(lanes, t - 1)));
        chk($sformatf("L%0d t%0d out_valid", lanes, t), 32'(ov), 32'(eov));
        chk($sformatf("L%0d t%0d out_data", lanes, t), od, eod);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " L4 out_data"}, bus4.out_data, 32'h0);
        chk({tag, " L4 out_valid"}, 32'(bus4.out_valid), 32'h0);
        chk({tag, " L4 ctrl"}, 32'({bus4.compute, bus4.busy, bus4.done, bus4.in_ready}), 32'h0);
        chk({tag, " L1 out_data"}, 32'(bus1.out_data), 32'h0);
        chk({tag, " L1 out_valid"}, 32'(bus1.out_valid), 32'h0);
        chk({tag, " L1 ctrl"}, 32'({bus1.compute, bus1.busy, bus1.done, bus1.in_ready}), 32'h0);
    endtask

    // mode: 0 random, 1 value 16k+i, 2 signed extremes (-128/127).
    task automatic run_tile(input int k, input int mode, input int stall_pct,
                            input int stall_cyc, input bit sfeed, input bit sdone,
                            input int rst_cyc);
        bit          ivv  [128];
        int          aidx [128];
        int          a, total;
        logic [31:0] data;
        for (int j = 0; j < 64; j++) begin
            tvec[j] = $urandom;
            for (int i = 0; i < 4; i++) begin
                if (mode == 1) tvec[j][i*8 +: 8] = 8'(16 * j + i);
                if (mode == 2) tvec[j][i*8 +: 8] = ((j + i) % 2 == 1) ? 8'h7f : 8'h80;
            end
        end
        tk    = k;
        a     = 0;
        tlast = 0;
        for (int c = 0; c < 128; c++) begin
            tacc[c] = 1'b0;
            aidx[c] = 0;
            if (c >= 1 && a < k) begin
                if (c == stall_cyc)  ivv[c] = 1'b0;
                else if (c > 60)     ivv[c] = 1'b1;
                else                 ivv[c] = ($urandom_range(99) >= stall_pct);
                if (ivv[c]) begin
                    tacc[c] = 1'b1;
                    aidx[c] = a;
                    a++;
                    tlast = c;
                end
            end else begin
                ivv[c] = 1'($urandom_range(1));
            end
        end
        total = (k == 0) ? 3 : tlast + 4 + 1;
        for (int t = 0; t <= total; t++) begin
            bus4.start    = (t == 0) || (sfeed && t == 2) || (sdone && t == done_cyc(4));
            bus1.start    = (t == 0) || (sfeed && t == 2) || (sdone && t == done_cyc(1));
            bus4.len      = (t == 0) ? 8'(k) : 8'($urandom);
            bus1.len      = bus4.len;
            data          = tacc[t] ? tvec[aidx[t]] : $urandom;
            bus4.in_valid = ivv[t];
            bus1.in_valid = ivv[t];
            bus4.in_data  = data;
            bus1.in_data  = data[7:0];
            rst           = (t == rst_cyc);
            @(negedge clk);
            if (rst_cyc >= 0 && t > rst_cyc) begin
                check_zero($sformatf("rst t%0d", t));
            end else if (t >= 1) begin
                check_dut(4, t, bus4.out_data, bus4.out_valid, bus4.in_ready, bus4.busy,
                          bus4.done, bus4.compute);
                check_dut(1, t, {24'h0, bus1.out_data}, {3'b0, bus1.out_valid},
                          bus1.in_ready, bus1.busy, bus1.done, bus1.compute);
            end
            @(posedge clk);
            #1;
            if (rst_cyc >= 0 && t > rst_cyc) break;
        end
        bus4.start    = 1'b0;
        bus1.start    = 1'b0;
        bus4.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
        rst           = 1'b0;
    endtask

    initial begin
        bus4.start = 1'b0; bus4.len = '0; bus4.in_valid = 1'b0; bus4.in_data = '0;
        bus1.start = 1'b0; bus1.len = '0; bus1.in_valid = 1'b0; bus1.in_data = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;

        // K=3, no stall, lane value 16k+i.
        run_tile(3, 1, 0, -1, 1'b0, 1'b0, -1);
        // Same tile with a single stall in cycle 2.
        run_tile(3, 1, 0, 2, 1'b0, 1'b0, -1);
        // Empty tile.
        run_tile(0, 0, 0, -1, 1'b0, 1'b0, -1);
        // K=2 (the 1-lane instance covers the no-drain case).
        run_tile(2, 0, 0, -1, 1'b0, 1'b0, -1);
        // Signed extremes, random stalls, START during FEED and in the DONE cycle.
        run_tile(6, 2, 20, -1, 1'b1, 1'b1, -1);
        // Reset in the middle of the 4-lane drain, then a normal tile.
        run_tile(3, 1, 0, -1, 1'b0, 1'b0, 5);
        run_tile(4, 0, 0, -1, 1'b0, 1'b0, -1);
        // Random tiles.
        for (int r = 0; r < 8; r++) begin
            run_tile(int'($urandom_range(1, 10)), 0, 30, -1, 1'($urandom_range(1)),
                     1'($urandom_range(1)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Operand feeder placed directly upstream of one edge of the systolic PE array. It accepts one operand vector of LANES elements per handshake and delays lane i by i extra cycles, so that operand k of lane i reaches edge PE i exactly i cycles after lane 0. It also generates the array's COMPUTE strobe and drains LANES-1 zero-padded cycles at the end of each tile. One instance feeds the row edge (OPND1) and one feeds the column edge (OPND2).

## Interface
- LANES, 4: array edge width, number of output lanes; must be ≥1.
- OPND_BWIDTH, 8: signed operand width (INT8).
- LEN_BWIDTH, 8: width of the tile length K.

- CLK  input  1  clock, all state updates on rising edge.
- RST  input  1  reset, synchronous, active-high.
- START  input  1  single-cycle tile start; sampled only in IDLE.
- LEN  input  LEN_BWIDTH  number of vectors K in the tile; captured with START.
- IN_VALID  input  1  upstream vector valid.
- IN_READY  output  1  feeder accepts the vector; high only in FEED.
- IN_DATA  input  LANES*OPND_BWIDTH  vector; lane i at bits [i*OPND_BWIDTH +: OPND_BWIDTH].
- OUT_DATA  output  LANES*OPND_BWIDTH  skewed operands to edge PEs, same packing.
- OUT_VALID  output  LANES  per-lane flag: OUT_DATA lane holds a real (non-pad) element.
- COMPUTE  output  1  array compute strobe; high in each cycle after a shift.
- BUSY  output  1  state ≠ IDLE.
- DONE  output  1  one-cycle pulse at the end of the tile.

## Operation
- Lane i has a chain of i+1 registers, d_i[0..i], plus a parallel valid-bit chain. OUT_DATA lane i = d_i[i]; OUT_VALID[i] = v_i[i].
- A shift moves every chain by one stage together: d_i[0] ← new element (or 0 during drain), d_i[j] ← d_i[j-1]. Valid chains shift the same way: v_i[0] ← 1 for accepted data, 0 for pad.
- A shift happens only on an accepted handshake (FEED, IN_VALID & IN_READY) or in a DRAIN cycle. If there is no shift, all chains hold, which keeps the lanes aligned under upstream stalls.
- FSM states:
  - IDLE: when START is high, capture LEN into a length register, clear all chains and valid bits, and clear the accepted-count cnt. Go to FEED, or to DONE_ST if LEN=0.
  - FEED: IN_READY=1. Each accept increments cnt. The accept that makes cnt=K goes to DRAIN, or to DONE_ST if LANES=1.
  - DRAIN: shift one zero pad every cycle, unconditionally, for LANES-1 cycles (counter dcnt). Then go to DONE_ST.
  - DONE_ST: a single cycle. DONE=1, then go to IDLE.
- COMPUTE is a register set to 1 in the cycle after each shift edge and 0 otherwise. Total COMPUTE-high cycles per tile = K+LANES-1 when K>0, and 0 when K=0.
- DONE coincides with the final COMPUTE-high cycle, which is the cycle where lane LANES-1 presents element K-1. When K=0, DONE pulses alone with COMPUTE low.
- START while BUSY is ignored. IN_DATA outside FEED is ignored.
- Leaving DONE_ST clears all OUT_VALID bits. OUT_DATA holds its last values until the next START clears the chains.
- Data passes through unmodified; there is no arithmetic on operands. cnt and dcnt are LEN_BWIDTH bits wide.

## Timing
- Reset (RST high at an edge): state IDLE, all chains and valid bits 0, cnt=0, dcnt=0. Outputs: OUT_DATA=0, OUT_VALID=0, COMPUTE=0, BUSY=0, DONE=0, IN_READY=0. Reset overrides any mid-tile state. There is no partial DONE.
- START sampled at edge e0 → BUSY and IN_READY high from cycle 1.
- Latency: the first accept at edge e1 shows lane 0 in cycle 2 with COMPUTE=1. Lane i shows element k i cycles after lane 0 shows it.
- An upstream stall of s cycles inserts s COMPUTE-low cycles. OUT_DATA is frozen during those cycles.
- Back-to-back tiles: the earliest next START is the cycle after DONE (IDLE). START in the DONE cycle is ignored.

## Test plan
- Reset: assert RST mid-DRAIN → next cycle all outputs 0, state IDLE, and the following START works normally.
- LANES=4, K=3, IN_VALID held high, lane values v(k,i)=16k+i:
  - START at cycle 0; IN_READY high in cycles 1–3; COMPUTE high in cycles 2–7; DONE only in cycle 7.
  - Lane i shows 16k+i in cycle 2+k+i with OUT_VALID[i]=1, and 0 with OUT_VALID=0 in its pad cycles.
- Same tile with IN_VALID low in cycle 2 only:
  - COMPUTE low in cycle 3; all OUT_DATA equal to their cycle-2 values.
  - Every subsequent event shifted by one cycle; DONE in cycle 8.
- K=0: START → DONE in cycle 1 and BUSY high for one cycle; no COMPUTE; IN_READY never high.
- LANES=1, K=2: COMPUTE in cycles 2–3; DONE in cycle 3; no DRAIN state.
- Signed extremes: lane values −128 and 127 pass through bit-exact. START during FEED is ignored, and LEN is not recaptured.
